// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: drives the pipeline-register enables and flushes,
// holds the pipeline during data-memory wait states and traps memory timeouts.
module pipeline_stall_ctrl #(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int                 WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [4:0]         en_s;     // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [2:0]         flush_s;  // {if_id, id_ex, ex_mem}
  logic               load_use_s;

  // Load in EX whose destination is read by the instruction in ID (x0 never hazards)
  always_comb begin
    load_use_s = ex_memread && (ex_rd != {REG_W{1'b0}}) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and Mealy enable/flush decode
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    en_s       = 5'b00000;
    flush_s    = 3'b000;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (mem_br_taken) begin
          en_s    = 5'b11111;
          flush_s = 3'b111;
        end else if (load_use_s) begin
          en_s    = 5'b00111;
          flush_s = 3'b010;
        end else begin
          en_s    = 5'b11111;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          en_s       = 5'b11111;
          state_d    = ST_RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Stall counter saturation and sticky timeout flag
  always_comb begin
    if (!en_s[4] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    mem_err_d = mem_err_q || (state_d == ST_ERROR);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= {WAIT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Controls are forced low for as long as reset is held
  always_comb begin
    if (arst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en_s;
      {if_id_flush, id_ex_flush, ex_mem_flush}          = flush_s;
    end else begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      {if_id_flush, id_ex_flush, ex_mem_flush}          = 3'b000;
    end
    stall_cnt = stall_cnt_q;
    mem_err   = mem_err_q;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a behavioural model queues the expected controls each
// cycle and an independent monitor compares them against the DUT.
module tb_pipeline_stall_ctrl;

  localparam int REG_W       = 5;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic             mem_br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;

  pipeline_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_br_taken(mem_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .stall_cnt(stall_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       ctl;   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl}
    logic [CNT_W-1:0] stall;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: error trap, outstanding memory wait and its length, stall tally
  bit m_err = 1'b0;
  bit m_wait = 1'b0;
  int m_wlen = 0;
  int m_stall = 0;

  task automatic model_push();
    exp_t e;
    logic [7:0] ctl;
    bit hazard;
    hazard = ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!arst_n) begin
      e.ctl = 8'h00; e.stall = '0; e.err = 1'b0;
      m_err = 1'b0; m_wait = 1'b0; m_wlen = 0; m_stall = 0;
      exp_q.push_back(e);
      return;
    end
    e.stall = CNT_W'(m_stall);
    e.err   = m_err;
    if (m_err) begin
      ctl = 8'b00000_000;
    end else if (m_wait) begin
      if (mem_ready) begin
        ctl = 8'b11111_000; m_wait = 1'b0; m_wlen = 0;
      end else begin
        ctl = 8'b00000_000; m_wlen++;
        if (m_wlen == MEM_TIMEOUT) m_err = 1'b1;
      end
    end else if (mem_req && !mem_ready) begin
      ctl = 8'b00000_000; m_wait = 1'b1; m_wlen = 1;
    end else if (mem_br_taken) begin
      ctl = 8'b11111_111;
    end else if (hazard) begin
      ctl = 8'b00111_010;
    end else begin
      ctl = 8'b11111_000;
    end
    if (!ctl[7] && m_stall < CNT_MAX) m_stall++;
    e.ctl = ctl;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, b, q, y, m, input logic [4:0] rd, s1, s2, input logic u1, u2);
    @(negedge clk);
    arst_n = r; mem_br_taken = b; mem_req = q; mem_ready = y; ex_memread = m;
    ex_rd = rd; id_rs1 = s1; id_rs2 = s2; id_use_rs1 = u1; id_use_rs2 = u2;
    #1;
    model_push();
  endtask

  // Monitor: every cycle the DUT presents a full control set, compared against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush};
      n_checks++;
      if (act === e.ctl) n_pass++;
      else $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
      n_checks++;
      if (stall_cnt === e.stall) n_pass++;
      else $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, e.stall);
      n_checks++;
      if (mem_err === e.err) n_pass++;
      else $display("FAIL mem_err t=%0t actual=%b required=%b", $time, mem_err, e.err);
    end
  end

  initial begin
    // reset, then independent ALU ops
    step(0,0,0,0,0, 0,0,0,0,0);
    step(0,0,0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 3; i++) step(1,0,0,0,0, 5'd3,5'd1,5'd2,1,1);
    // load-use on rs2, then one clean cycle
    step(1,0,0,0,1, 5'd5,5'd1,5'd5,1,1);
    step(1,0,0,0,0, 5'd5,5'd1,5'd5,1,1);
    // x0 destination and unused rs2 never stall
    step(1,0,0,0,1, 5'd0,5'd1,5'd0,1,1);
    step(1,0,0,0,1, 5'd5,5'd1,5'd5,1,0);
    // load-use on rs1
    step(1,0,0,0,1, 5'd7,5'd7,5'd2,1,0);
    // branch outranks load-use
    step(1,1,0,0,1, 5'd5,5'd1,5'd5,1,1);
    // three wait states then ready
    step(1,0,1,0,0, 0,0,0,0,0);
    step(1,0,1,0,0, 0,0,0,0,0);
    step(1,0,1,0,0, 0,0,0,0,0);
    step(1,0,1,1,0, 0,0,0,0,0);
    step(1,0,0,0,0, 0,0,0,0,0);
    // timeout into ERROR; ready is then ignored
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1,0,1,0,0, 0,0,0,0,0);
    step(1,0,1,1,0, 0,0,0,0,0);
    step(1,1,0,1,0, 0,0,0,0,0);
    step(1,0,0,0,0, 0,0,0,0,0);
    // reset pulse returns to RUN
    step(0,0,1,0,0, 0,0,0,0,0);
    step(1,0,0,0,0, 0,0,0,0,0);
    // reset in the middle of a wait
    step(1,0,1,0,0, 0,0,0,0,0);
    step(1,0,1,0,0, 0,0,0,0,0);
    step(0,0,1,0,0, 0,0,0,0,0);
    step(1,0,0,0,0, 0,0,0,0,0);
    // stall counter saturation
    for (int i = 0; i < CNT_MAX + 3; i++) step(1,0,0,0,1, 5'd2,5'd2,5'd2,1,1);
    step(0,0,0,0,0, 0,0,0,0,0);
    // randomized traffic, biased toward hazards and waits
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
    repeat (3) @(negedge clk);
    #5;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain actual=%0d pending required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
